// File: rtl/sbox_gen_ctrl_pkg.sv
// Shared definitions for the S-box generation sequencer.
// Provides the state encoding, S-box geometry, default timing
// parameters and the write-port payload type.
package sbox_gen_ctrl_pkg;

    localparam int unsigned SBOX_SIZE        = 256;
    localparam int unsigned SBOX_AW          = 8;
    localparam int unsigned FILL_W           = SBOX_AW + 1;
    localparam int unsigned PIPE_LAT_DEF     = 3;
    localparam int unsigned MAX_ATTEMPTS_DEF = 4096;
    localparam int unsigned ATT_W_DEF        = 13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    // One S-box store write: index and value.
    typedef struct packed {
        logic [SBOX_AW-1:0] addr;
        logic [SBOX_AW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/sbox_gen_ctrl_if.sv
// Pipeline/store interface of the S-box sequencer.
//   src_enable : enable for the read/extract stages
//   cand_valid : candidate byte present this cycle
//   cand_byte  : candidate S-box value
//   wr_en/wr_addr/wr_data : S-box store write port
// master = sequencer side, slave = pipeline and store side.
interface sbox_gen_ctrl_if;
    import sbox_gen_ctrl_pkg::*;

    logic               src_enable;
    logic               cand_valid;
    logic [SBOX_AW-1:0] cand_byte;
    logic               wr_en;
    logic [SBOX_AW-1:0] wr_addr;
    logic [SBOX_AW-1:0] wr_data;

    modport master (
        output src_enable, wr_en, wr_addr, wr_data,
        input  cand_valid, cand_byte
    );

    modport slave (
        input  src_enable, wr_en, wr_addr, wr_data,
        output cand_valid, cand_byte
    );

endinterface

// File: rtl/sbox_gen_ctrl_uniq_bitmap.sv
// 256-entry uniqueness bitmap.
//   clear  : synchronous clear of the whole array (wins over set)
//   set_en : set bit idx on the next edge
//   idx    : byte under test
//   hit_c  : combinational, bit idx already set
module sbox_gen_ctrl_uniq_bitmap
    import sbox_gen_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               set_en,
    input  logic [SBOX_AW-1:0] idx,
    output logic               hit_c
);

    logic [SBOX_SIZE-1:0] bits_q;
    logic [SBOX_SIZE-1:0] bits_d;

    assign hit_c = bits_q[idx];

    // Next bitmap contents.
    always_comb begin
        bits_d = bits_q;
        if (clear) begin
            bits_d = '0;
        end else if (set_en) begin
            bits_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

endmodule

// File: rtl/sbox_gen_ctrl.sv
// Sequencer for the chaos-driven S-box generation pipeline.
// Starts/stops the source, drops warm-up candidates, filters duplicates
// and writes unique bytes sequentially into the S-box store.
//   clk, rst   : clock, synchronous active-high reset
//   start      : run request pulse (honoured in IDLE/DONE/ERROR)
//   abort      : cancels an active run (PRIME/RUN)
//   bus        : candidate stream in, source enable and store write out
//   busy       : PRIME or RUN
//   done/error : sticky completion / attempt-limit flags
//   attempts   : candidates examined in current or last run
module sbox_gen_ctrl
    import sbox_gen_ctrl_pkg::*;
#(
    parameter int unsigned PIPE_LAT     = PIPE_LAT_DEF,
    parameter int unsigned MAX_ATTEMPTS = MAX_ATTEMPTS_DEF,
    parameter int unsigned ATT_W        = ATT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    sbox_gen_ctrl_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [ATT_W-1:0] attempts
);

    localparam int unsigned PC_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    prime_cnt_q, prime_cnt_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [ATT_W-1:0]   attempts_q, attempts_d;
    wr_req_t            wr_q, wr_d;
    logic               wr_en_q, wr_en_d;
    logic               src_enable_q, src_enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               bm_clear, bm_set, bm_hit_c;

    sbox_gen_ctrl_uniq_bitmap u_bitmap (
        .clk    (clk),
        .rst    (rst),
        .clear  (bm_clear),
        .set_en (bm_set),
        .idx    (bus.cand_byte),
        .hit_c  (bm_hit_c)
    );

    // Next-state and registered-output logic; outputs track the state entered.
    always_comb begin
        state_d      = state_q;
        prime_cnt_d  = prime_cnt_q;
        fill_d       = fill_q;
        attempts_d   = attempts_q;
        wr_d         = wr_q;
        wr_en_d      = 1'b0;
        src_enable_d = src_enable_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        bm_clear     = 1'b0;
        bm_set       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_PRIME;
                    prime_cnt_d  = '0;
                    fill_d       = '0;
                    attempts_d   = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    bm_clear     = 1'b1;
                    src_enable_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_PRIME: begin
                if (abort) begin
                    state_d      = ST_IDLE;
                    src_enable_d = 1'b0;
                    busy_d       = 1'b0;
                end else if (prime_cnt_q == PC_W'(PIPE_LAT - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    prime_cnt_d = prime_cnt_q + PC_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d      = ST_IDLE;
                    src_enable_d = 1'b0;
                    busy_d       = 1'b0;
                end else if (bus.cand_valid) begin
                    if (attempts_q != ATT_W'(MAX_ATTEMPTS)) begin
                        attempts_d = attempts_q + ATT_W'(1);
                    end
                    if (!bm_hit_c) begin
                        bm_set    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_d.addr = fill_q[SBOX_AW-1:0];
                        wr_d.data = bus.cand_byte;
                        fill_d    = fill_q + FILL_W'(1);
                    end
                    // Completion is checked first so a final unique byte on the
                    // last allowed attempt finishes the run rather than failing it.
                    if (fill_d == FILL_W'(SBOX_SIZE)) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        src_enable_d = 1'b0;
                        busy_d       = 1'b0;
                    end else if (attempts_d == ATT_W'(MAX_ATTEMPTS)) begin
                        state_d      = ST_ERROR;
                        error_d      = 1'b1;
                        src_enable_d = 1'b0;
                        busy_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                src_enable_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prime_cnt_q  <= '0;
            fill_q       <= '0;
            attempts_q   <= '0;
            wr_q         <= '0;
            wr_en_q      <= 1'b0;
            src_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prime_cnt_q  <= prime_cnt_d;
            fill_q       <= fill_d;
            attempts_q   <= attempts_d;
            wr_q         <= wr_d;
            wr_en_q      <= wr_en_d;
            src_enable_q <= src_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.src_enable = src_enable_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_q.addr;
    assign bus.wr_data    = wr_q.data;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign attempts       = attempts_q;

endmodule

// File: tb/tb_sbox_gen_ctrl.sv
// Bench for sbox_gen_ctrl: three instances (attempt limits 4096, 8, 256)
// share one stimulus stream; each is compared every cycle against its own
// behavioural model of the run rules.
module tb_sbox_gen_ctrl;

    localparam int unsigned NI  = 3;
    localparam int unsigned LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, cand_valid;
    logic [7:0] cand_byte;

    logic        o_src[NI], o_wen[NI], o_busy[NI], o_done[NI], o_err[NI];
    logic [7:0]  o_addr[NI], o_data[NI];
    logic [12:0] o_att[NI];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned MAXV = (g == 0) ? 4096 : ((g == 1) ? 8 : 256);
        sbox_gen_ctrl_if bus ();
        assign bus.cand_valid = cand_valid;
        assign bus.cand_byte  = cand_byte;
        assign o_src[g]  = bus.src_enable;
        assign o_wen[g]  = bus.wr_en;
        assign o_addr[g] = bus.wr_addr;
        assign o_data[g] = bus.wr_data;
        sbox_gen_ctrl #(.PIPE_LAT(LAT), .MAX_ATTEMPTS(MAXV), .ATT_W(13)) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .abort    (abort),
            .bus      (bus),
            .busy     (o_busy[g]),
            .done     (o_done[g]),
            .error    (o_err[g]),
            .attempts (o_att[g])
        );
    end

    // Behavioural model: per instance, whether a run is active, warm-up
    // cycles still to skip, set of bytes already used and run counters.
    int  m_max[NI] = '{4096, 8, 256};
    bit  m_act[NI], m_done[NI], m_err[NI], m_wen[NI];
    int  m_warm[NI], m_fill[NI], m_att[NI], m_addr[NI], m_data[NI];
    bit  m_seen[NI][256];

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_act[k] = 0; m_done[k] = 0; m_err[k] = 0; m_wen[k] = 0;
            m_warm[k] = 0; m_fill[k] = 0; m_att[k] = 0; m_addr[k] = 0; m_data[k] = 0;
            for (int b = 0; b < 256; b++) m_seen[k][b] = 0;
        end
    endtask

    task automatic model_edge(input bit st, input bit ab, input bit cv, input int cb);
        for (int k = 0; k < NI; k++) begin
            m_wen[k] = 0;
            if (!m_act[k]) begin
                if (st) begin
                    m_act[k] = 1; m_warm[k] = LAT; m_fill[k] = 0; m_att[k] = 0;
                    m_done[k] = 0; m_err[k] = 0;
                    for (int b = 0; b < 256; b++) m_seen[k][b] = 0;
                end
            end else if (ab) begin
                m_act[k] = 0;
            end else if (m_warm[k] > 0) begin
                m_warm[k]--;
            end else if (cv) begin
                if (m_att[k] < m_max[k]) m_att[k]++;
                if (!m_seen[k][cb]) begin
                    m_seen[k][cb] = 1;
                    m_wen[k] = 1; m_addr[k] = m_fill[k]; m_data[k] = cb;
                    m_fill[k]++;
                end
                if (m_fill[k] == 256) begin
                    m_done[k] = 1; m_act[k] = 0;
                end else if (m_att[k] >= m_max[k]) begin
                    m_err[k] = 1; m_act[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h at %0t", tag, k, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk("src_enable", k, 32'(o_src[k]),  32'(m_act[k]));
            chk("busy",       k, 32'(o_busy[k]), 32'(m_act[k]));
            chk("done",       k, 32'(o_done[k]), 32'(m_done[k]));
            chk("error",      k, 32'(o_err[k]),  32'(m_err[k]));
            chk("attempts",   k, 32'(o_att[k]),  32'(m_att[k]));
            chk("wr_en",      k, 32'(o_wen[k]),  32'(m_wen[k]));
            chk("wr_addr",    k, 32'(o_addr[k]), 32'(m_addr[k]));
            chk("wr_data",    k, 32'(o_data[k]), 32'(m_data[k]));
        end
    endtask

    task automatic step(input bit st, input bit ab, input bit cv, input logic [7:0] cb);
        start = st; abort = ab; cand_valid = cv; cand_byte = cb;
        @(posedge clk);
        model_edge(st, ab, cv, int'(cb));
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; start = 1'b0; abort = 1'b0; cand_valid = 1'b0; cand_byte = 8'h00;
        repeat (n) begin
            @(posedge clk);
            model_reset();
            #1;
            check_all();
        end
        rst = 1'b0;
    endtask

    task automatic prime_idle();
        repeat (LAT) step(0, 0, 0, 8'h00);
    endtask

    initial begin
        do_reset(2);

        // Idle: no start, random candidate pulses must not write.
        repeat (10) step(0, 0, 1'($urandom_range(0, 1)), 8'($urandom));

        // Warm-up drop: 0x55 every cycle from the start edge on.
        step(1, 0, 0, 8'h00);
        repeat (8) step(0, 0, 1, 8'h55);
        chk("prime_attempts", 0, 32'(o_att[0]), 32'd5);

        // Full unique sweep; start while busy is ignored on the way in.
        step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        repeat (LAT - 1) step(0, 0, 0, 8'h00);
        for (int i = 0; i < 256; i++) step(0, 0, 1, 8'(i));
        chk("sweep_done",     0, 32'(o_done[0]), 32'd1);
        chk("sweep_last_adr", 0, 32'(o_addr[0]), 32'd255);
        chk("race_done",      2, 32'(o_done[2]), 32'd1);
        chk("race_error",     2, 32'(o_err[2]),  32'd0);
        chk("lim8_error",     1, 32'(o_err[1]),  32'd1);
        repeat (3) step(0, 0, 1, 8'($urandom));

        // Duplicates, started from DONE/ERROR.
        step(1, 0, 0, 8'h00);
        prime_idle();
        step(0, 0, 1, 8'h10);
        step(0, 0, 1, 8'h10);
        step(0, 0, 1, 8'h20);
        step(0, 0, 1, 8'h10);
        step(0, 0, 0, 8'h00);
        chk("dup_attempts", 0, 32'(o_att[0]), 32'd4);

        // Attempt limit with a repeated byte, then restart of the errored instance.
        step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        prime_idle();
        repeat (10) step(0, 0, 1, 8'h01);
        chk("err_flag", 1, 32'(o_err[1]),  32'd1);
        chk("err_done", 1, 32'(o_done[1]), 32'd0);
        step(1, 0, 1, 8'h01);
        prime_idle();
        step(0, 0, 1, 8'h77);
        chk("restart_adr", 1, 32'(o_addr[1]), 32'd0);

        // Abort after five unique writes, then reuse of the same bytes.
        step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        prime_idle();
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'hA0 + i));
        step(0, 1, 1, 8'hA5);
        step(0, 0, 1, 8'hA6);
        step(1, 0, 0, 8'h00);
        prime_idle();
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'hA0 + i));

        // Start and abort together while busy: abort wins.
        step(1, 1, 1, 8'hB0);
        step(0, 0, 1, 8'hB1);

        // Reset in the middle of a run.
        step(1, 0, 0, 8'h00);
        prime_idle();
        repeat (4) step(0, 0, 1, 8'($urandom));
        do_reset(1);
        step(0, 0, 1, 8'h33);

        // Random traffic.
        repeat (2000) begin
            step(1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 399) < 1),
                 1'($urandom_range(0, 99) < 75),
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
